// File: rtl/hall_emulator.sv
// Emulated BLDC hall sensor source: six-sector 120-degree pattern whose step
// interval ramps linearly from START_PERIOD toward a programmable target.
module hall_emulator #(
  parameter int PERIOD_W     = 16,
  parameter int START_PERIOD = 2700,
  parameter int RAMP_DEC     = 100,
  parameter int MIN_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] target_period,
  input  logic                fault_inject,
  output logic [2:0]          HS,
  output logic [2:0]          sector,
  output logic                step_pulse,
  output logic                running,
  output logic [15:0]         rev_count
);

  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DEC     = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W:0]   DEC_X   = (PERIOD_W+1)'(RAMP_DEC);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  state_t              state;
  logic [PERIOD_W-1:0] cur_period;
  logic [PERIOD_W-1:0] timer;

  logic [PERIOD_W-1:0] target_eff;
  logic [PERIOD_W:0]   cur_x, tgt_x;
  logic [PERIOD_W-1:0] period_upd;
  logic                step;
  logic [2:0]          sec_step, sec_nxt;

  function automatic logic [2:0] code(input logic [2:0] s);
    case (s)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b011;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b100;
      default: code = 3'b101;
    endcase
  endfunction

  always_comb begin
    target_eff = (target_period < MIN_P) ? MIN_P : target_period;
    cur_x      = {1'b0, cur_period};
    tgt_x      = {1'b0, target_eff};
    // Comparisons are widened one bit so the +/- step never wraps; the chosen
    // result always lies between cur_period and target_eff.
    period_upd = target_eff;
    if (cur_x > tgt_x + DEC_X)
      period_upd = cur_period - DEC;
    else if (cur_x + DEC_X < tgt_x)
      period_upd = cur_period + DEC;

    step = enable && (state != IDLE) && (timer == cur_period - ONE);

    if (dir) sec_step = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    else     sec_step = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
    sec_nxt = step ? sec_step : sector;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sector     <= 3'd0;
      HS         <= 3'b001;
      step_pulse <= 1'b0;
      running    <= 1'b0;
      rev_count  <= 16'd0;
      cur_period <= START_P;
      timer      <= '0;
    end else begin
      step_pulse <= 1'b0;
      // HS follows the sector that is current after this edge unless forced.
      HS         <= fault_inject ? 3'b111 : code(sec_nxt);
      if (!enable) begin
        state   <= IDLE;
        running <= 1'b0;
        timer   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= RAMP;
            running    <= 1'b1;
            cur_period <= START_P;
            timer      <= '0;
          end
          RAMP, RUN: begin
            if (step) begin
              timer      <= '0;
              step_pulse <= 1'b1;
              sector     <= sec_step;
              cur_period <= period_upd;
              state      <= (period_upd == target_eff) ? RUN : RAMP;
              if (dir && sector == 3'd5)       rev_count <= rev_count + 16'd1;
              else if (!dir && sector == 3'd0) rev_count <= rev_count - 16'd1;
            end else begin
              timer <= timer + ONE;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hall_emulator.sv
// Directed bench for hall_emulator with a small start period so ramps are short.
module tb_hall_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        dir;
  logic [15:0] target_period;
  logic        fault_inject;
  logic [2:0]  HS;
  logic [2:0]  sector;
  logic        step_pulse;
  logic        running;
  logic [15:0] rev_count;

  int checks = 0;
  int errors = 0;

  hall_emulator #(
    .PERIOD_W(16), .START_PERIOD(100), .RAMP_DEC(10), .MIN_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir),
    .target_period(target_period), .fault_inject(fault_inject),
    .HS(HS), .sector(sector), .step_pulse(step_pulse),
    .running(running), .rev_count(rev_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [15:0] tgt;
    int          intv;
    logic [2:0]  hs;
    logic [2:0]  sec;
    logic [15:0] rev;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, input logic [15:0] t, input int iv,
                     input logic [2:0] h, input logic [2:0] s, input logic [15:0] r);
    vecs.push_back('{d, t, iv, h, s, r});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges from the current reference point until a step_pulse is seen.
  task automatic wait_step(output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      seen = step_pulse;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: no step_pulse within %0d cycles", n);
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("running_on_start", running, 1);
  endtask

  task automatic run_rows(input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) begin
      dir = vecs[i].dir;
      target_period = vecs[i].tgt;
      wait_step(n);
      chk($sformatf("interval[%0d]", i), n, vecs[i].intv);
      chk($sformatf("hs[%0d]", i), HS, vecs[i].hs);
      chk($sformatf("sector[%0d]", i), sector, vecs[i].sec);
      chk($sformatf("rev[%0d]", i), rev_count, vecs[i].rev);
      chk($sformatf("running[%0d]", i), running, 1);
    end
  endtask

  initial begin
    int n;
    int pulses;
    int hs_bad;
    // ramp down 100 -> 50 forward
    add(1, 50, 100, 3'b011, 1, 0);
    add(1, 50,  90, 3'b010, 2, 0);
    add(1, 50,  80, 3'b110, 3, 0);
    add(1, 50,  70, 3'b100, 4, 0);
    add(1, 50,  60, 3'b101, 5, 0);
    add(1, 50,  50, 3'b001, 0, 1);
    add(1, 50,  50, 3'b011, 1, 1);
    // retarget upward to 75
    add(1, 75,  50, 3'b010, 2, 1);
    add(1, 75,  60, 3'b110, 3, 1);
    add(1, 75,  70, 3'b100, 4, 1);
    add(1, 75,  75, 3'b101, 5, 1);
    add(1, 75,  75, 3'b001, 0, 2);
    // direction reversal mid-run, interval unchanged
    add(0, 75,  75, 3'b101, 5, 1);
    add(0, 75,  75, 3'b100, 4, 1);
    add(1, 75,  75, 3'b101, 5, 1);
    add(1, 75,  75, 3'b001, 0, 2);
    // target 0 clamps to MIN_PERIOD
    add(1, 0,   75, 3'b011, 1, 2);
    add(1, 0,   65, 3'b010, 2, 2);
    add(1, 0,   55, 3'b110, 3, 2);
    add(1, 0,   45, 3'b100, 4, 2);
    add(1, 0,   35, 3'b101, 5, 2);
    add(1, 0,   25, 3'b001, 0, 3);
    add(1, 0,   15, 3'b011, 1, 3);
    add(1, 0,    5, 3'b010, 2, 3);
    add(1, 0,    4, 3'b110, 3, 3);
    add(1, 0,    4, 3'b100, 4, 3);
    // reverse from reset
    add(0, 100, 100, 3'b101, 5, 16'hFFFF);
    add(0, 100, 100, 3'b100, 4, 16'hFFFF);
    add(0, 100, 100, 3'b110, 3, 16'hFFFF);

    rst_n = 1'b0; enable = 1'b0; dir = 1'b1; target_period = 16'd50; fault_inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", HS, 3'b001);
    chk("rst_sector", sector, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_running", running, 0);
    chk("rst_rev", rev_count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_running", running, 0);
    chk("idle_hs", HS, 3'b001);

    start_run();
    run_rows(0, 25);

    // fault injection: sector 4, period 4; two steps land inside the window
    fault_inject = 1'b1;
    hs_bad = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (HS !== 3'b111) hs_bad++;
      if (step_pulse) pulses++;
    end
    chk("fault_hs_cycles_bad", hs_bad, 0);
    chk("fault_pulses", pulses, 2);
    chk("fault_sector", sector, 0);
    chk("fault_rev", rev_count, 4);
    fault_inject = 1'b0;
    target_period = 16'd50;
    @(negedge clk);
    chk("fault_release_hs", HS, 3'b001);

    // ramp up 4 -> 50: steps at 4,14,24,34,44 then 50
    for (int i = 0; i < 6; i++) wait_step(n);
    chk("up_interval", n, 50);
    chk("up_sector", sector, 0);
    chk("up_rev", rev_count, 5);

    // stop with timer at 30 of 50
    repeat (30) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("stop_running", running, 0);
    pulses = 0;
    hs_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
      if (HS !== 3'b001) hs_bad++;
    end
    chk("stop_pulses", pulses, 0);
    chk("stop_hs_bad", hs_bad, 0);
    chk("stop_sector", sector, 0);
    chk("stop_rev", rev_count, 5);

    // restart uses START_PERIOD again
    start_run();
    wait_step(n);
    chk("restart_interval", n, 100);
    chk("restart_sector", sector, 1);
    chk("restart_hs", HS, 3'b011);

    // asynchronous reset between edges
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hs", HS, 3'b001);
    chk("async_sector", sector, 0);
    chk("async_rev", rev_count, 0);
    chk("async_running", running, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dir = 1'b0;
    target_period = 16'd100;
    @(negedge clk);
    start_run();
    run_rows(26, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
